data_sram_resp: RTL
===================

// Module: data_sram_resp
// PURPOSE
// Responder end of the data SRAM interface driven by the EX stage: accepts en/wen/addr/wdata
// requests, commits byte-lane writes into a word-organised on-chip array and returns registered
// read data to the MEM stage one cycle after the access executes. Optional wait states hold the
// pipeline via a stall request so slower memory timing can be modelled without changing EX/MEM.
// PARAMETERS
// DEPTH        4096      number of 32-bit words in the array (power of two)
// BASE_ADDR    32'h0     byte address mapped to word 0
// WAIT_CYCLES  0         stall cycles inserted before each access executes (0..15)
// PORTS
// clk               in   1   clock, all state updates on posedge
// rst               in   1   synchronous active-high reset
// data_sram_en      in   1   access request valid
// data_sram_wen     in   4   byte-lane write enables; 4'b0000 with en=1 means read
// data_sram_addr    in   32  byte address
// data_sram_wdata   in   32  write data, lanes already replicated by requester
// data_sram_rdata   out  32  registered read data, full word (MEM stage extracts bytes)
// stallreq_for_mem  out  1   high while the current request must be held stable
// addr_err          out  1   one-cycle pulse, aligned with rdata, for an out-of-range access
// BEHAVIOUR
// - Reset: data_sram_rdata=0, addr_err=0, stallreq_for_mem=0, FSM=IDLE. Array is NOT cleared;
//   reset mid-wait discards the pending access (no write commits, rdata stays 0).
// - Decode: off = addr - BASE_ADDR (32-bit wrap); in range iff off < DEPTH*4;
//   word index = off[log2(DEPTH)+1:2]; addr[1:0] ignored for indexing, lanes come from wen.
// - Execute (en=1 in execute cycle E): wen!=0 -> lanes with wen[i]=1 get wdata[8i+7:8i] at end
//   of E, rdata holds; wen==0 -> rdata <= array word at end of E, valid throughout E+1.
// - rdata changes only on executed in-range reads (out-of-range read loads 0); holds otherwise.
// - Out of range: write dropped, read returns 0, addr_err=1 for exactly cycle E+1.
// - en=0: nothing happens regardless of wen/addr/wdata.
// - WAIT_CYCLES=0: FSM stays IDLE, stallreq_for_mem=0 always, E = cycle request is presented.
// - WAIT_CYCLES=N>0, request first seen in cycle T: stallreq_for_mem=1 in cycles T..T+N-1
//   (combinational from en in T), 0 in T+N; E=T+N. Inputs sampled only in E.
//   States: IDLE  --en & N==1--> DONE; IDLE --en & N>1--> WAIT (cnt=N-1)
//           WAIT  cnt>1: cnt-- stay; cnt==1 -> DONE   (stallreq=1 in WAIT)
//           DONE  stallreq=0, access executes, -> IDLE unconditionally.
//   en=1 again in cycle after DONE is a new request and restarts the sequence.
// - Read-after-write: store executed in E, load to same word executed in E+1 returns new data.
// - Simultaneous sub-word writes to one word in consecutive cycles merge lane-wise.
// TESTING
// - W=0: sw 0x00000010<-0xDEADBEEF at T, lw 0x10 at T+1 -> rdata=0xDEADBEEF at T+2, stall never 1.
// - Byte lanes: word 0x20=0x11223344, sb wen=4'b0100 wdata=0xAAAAAAAA, then lw -> 0x11AA3344.
// - W=3: lw held from T -> stallreq 1 at T,T+1,T+2, 0 at T+3, rdata valid T+4; back-to-back lw
//   at T+4 stalls T+4..T+6.
// - Range: DEPTH=1024, BASE=0x1000: sw 0x0FFC and sw 0x2000 dropped, lw 0x2000 -> rdata=0,
//   addr_err=1 one cycle; lw 0x1FFC in range, addr_err=0.
// - Reset: W=4, assert rst at T+2 of a sw -> target word unchanged, stallreq=0 next cycle,
//   rdata=0; previously written words still readable after reset.
// - en=0 with wen=4'hF, addr=0x10: word 0x10 unchanged, rdata holds prior value.

Source files
------------

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-lane writes into a word array, registered full-word reads,
// optional wait states that hold the requester through stallreq_for_mem.
module data_sram_resp #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        addr_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [32:0] BYTES = 33'(DEPTH) << 2;
  localparam logic [3:0]  W     = WAIT_CYCLES[3:0];

  // state  | meaning
  // S_IDLE | no request pending; with W=0 the access executes here
  // S_WAIT | counting down wait states, requester stalled
  // S_DONE | stall released, held request executes this cycle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_stall;
  logic        w_exec;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_off;
  logic        w_in_range;
  logic [AW-1:0] w_idx;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic        r_addr_err;

  assign w_off      = data_sram_addr - BASE_ADDR;
  assign w_in_range = {1'b0, w_off} < BYTES;
  assign w_idx      = w_off[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (W == 4'd0) begin
          w_exec = data_sram_en;
        end else if (data_sram_en) begin
          w_stall = 1'b1;
          if (W == 4'd1) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = W - 4'd1;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt > 4'd1) w_cnt_nxt = r_cnt - 4'd1;
        else              w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_exec      = data_sram_en;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset in the execute cycle cancels the access as well as the FSM.
  assign w_wr = w_exec & ~rst & w_in_range & (|data_sram_wen);
  assign w_rd = w_exec & ~(|data_sram_wen);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_in_range ? r_mem[w_idx] : 32'h0;
      r_addr_err <= w_exec & ~w_in_range;
    end
  end

  assign data_sram_rdata  = r_rdata;
  assign addr_err         = r_addr_err;
  assign stallreq_for_mem = w_stall & ~rst;

endmodule
